// File: rtl/accel_pkg.sv
// Shared types, constants and field extraction for the accelerometer BCD scheduler.
package accel_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StShift
  } state_e;

  localparam int unsigned VAL_W        = 10;
  localparam int unsigned DIGITS       = 4;
  localparam int unsigned SHIFT_CYCLES = 10;

  // Magnitude field spread across the SPI register pair; reg0[5:0] carries no magnitude.
  function automatic logic [VAL_W-1:0] extract_val(input logic [7:0] reg0, input logic [7:0] reg1);
    return {reg1, reg0[6], reg0[7]};
  endfunction

endpackage

// File: rtl/accel_bcd_scheduler_if.sv
// Request/result bundle between sample sources, the scheduler and the display path.
interface accel_bcd_scheduler_if #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
);

  logic [NUM_REQ-1:0]    req;
  logic [16*NUM_REQ-1:0] accel_data;
  logic [NUM_REQ-1:0]    ack;
  logic                  busy;
  logic                  result_valid;
  logic [ID_W-1:0]       result_id;
  logic [3:0]            ones;
  logic [3:0]            tens;
  logic [3:0]            hundreds;
  logic [3:0]            thousands;

  modport master (
    output req, accel_data,
    input  ack, busy, result_valid, result_id, ones, tens, hundreds, thousands
  );

  modport slave (
    input  req, accel_data,
    output ack, busy, result_valid, result_id, ones, tens, hundreds, thousands
  );

endinterface

// File: rtl/bcd_shift_core.sv
// Sequential double-dabble core: one add-3/shift step per enabled cycle.
module bcd_shift_core
  import accel_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [VAL_W-1:0]      start_val,
  input  logic                  step,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  done
);

  // Marker bit trails the value; it reaching the top of the field flags the final step.
  localparam logic [VAL_W-1:0] LastMark = VAL_W'(1) << (VAL_W - 1);

  logic [4*DIGITS-1:0] scratch_q, scratch_adj, scratch_nxt;
  logic [VAL_W:0]      sh_q;

  always_comb begin
    scratch_adj = scratch_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
    scratch_nxt = (scratch_adj << 1) | {{(4*DIGITS-1){1'b0}}, sh_q[VAL_W]};
    digits      = scratch_nxt;
    done        = step && (sh_q[VAL_W-1:0] == LastMark);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      scratch_q <= '0;
      sh_q      <= '0;
    end else if (start) begin
      scratch_q <= '0;
      sh_q      <= {start_val, 1'b1};
    end else if (step) begin
      scratch_q <= scratch_nxt;
      sh_q      <= sh_q << 1;
    end
  end

endmodule

// File: rtl/accel_bcd_scheduler.sv
// Round-robin scheduler sharing one BCD converter among accelerometer axis sources.
module accel_bcd_scheduler
  import accel_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = 2
) (
  input logic                  clk,
  input logic                  reset,
  accel_bcd_scheduler_if.slave bus
);

  state_e               state_q;
  logic [ID_W-1:0]      rr_q, gid_q, rid_q, gnt_idx;
  logic [3:0]           cnt_q;
  logic [NUM_REQ-1:0]   ack_q;
  logic                 busy_q, rv_q, gnt_any;
  logic [4*DIGITS-1:0]  dig_q, core_digits;
  logic [15:0]          gnt_word;
  logic                 core_start, core_step, core_done;

  // Two passes: sources at/after the pointer first, then the wrapped ones.
  always_comb begin
    gnt_any  = 1'b0;
    gnt_idx  = '0;
    gnt_word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && bus.req[i] && (ID_W'(i) >= rr_q)) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!gnt_any && bus.req[i]) begin
        gnt_any = 1'b1;
        gnt_idx = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) begin
        gnt_word = bus.accel_data[16*i +: 16];
      end
    end
  end

  assign core_start = (state_q == StIdle) && gnt_any;
  assign core_step  = (state_q == StShift);

  bcd_shift_core u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (core_start),
    .start_val (extract_val(gnt_word[15:8], gnt_word[7:0])),
    .step      (core_step),
    .digits    (core_digits),
    .done      (core_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rr_q    <= '0;
      gid_q   <= '0;
      rid_q   <= '0;
      cnt_q   <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      dig_q   <= '0;
    end else begin
      ack_q <= '0;
      rv_q  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (gnt_any) begin
            ack_q   <= NUM_REQ'(1) << gnt_idx;
            gid_q   <= gnt_idx;
            rr_q    <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
            cnt_q   <= 4'(SHIFT_CYCLES - 1);
            busy_q  <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          cnt_q <= cnt_q - 1'b1;
          if (core_done) begin
            dig_q   <= core_digits;
            rid_q   <= gid_q;
            rv_q    <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ack          = ack_q;
  assign bus.busy         = busy_q;
  assign bus.result_valid = rv_q;
  assign bus.result_id    = rid_q;
  assign bus.ones         = dig_q[3:0];
  assign bus.tens         = dig_q[7:4];
  assign bus.hundreds     = dig_q[11:8];
  assign bus.thousands    = dig_q[15:12];

endmodule

// File: tb/tb_accel_bcd_scheduler.sv
// Scoreboard bench: a cycle model predicts grants/results, checked every negedge.
module tb_accel_bcd_scheduler;

  localparam int NReq = 3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  accel_bcd_scheduler_if #(.NUM_REQ(NReq), .ID_W(2)) bus ();

  accel_bcd_scheduler #(.NUM_REQ(NReq), .ID_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {int id; int val;} exp_t;
  exp_t sbq[$];

  logic [NReq-1:0]    req_s = '0;
  logic [16*NReq-1:0] data_s = '0;
  logic               rst_s = 1'b1;
  bit                 m_idle = 1'b1;
  int                 m_cnt = 0;
  int                 m_rr = 0;
  logic [17:0]        hold = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int field(input logic [15:0] w);
    return int'({w[7:0], w[14], w[15]});
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    req_s  <= bus.req;
    data_s <= bus.accel_data;
    rst_s  <= reset;
  end

  logic [17:0] obs_res;
  assign obs_res = {bus.result_id, bus.thousands, bus.hundreds, bus.tens, bus.ones};

  // Reference model evaluated against the inputs seen at the preceding posedge.
  always @(negedge clk) begin
    logic [NReq-1:0] exp_ack;
    bit              exp_rv;
    int              g;
    exp_t            e;
    if (rst_s) begin
      m_idle = 1'b1;
      m_cnt  = 0;
      m_rr   = 0;
      sbq.delete();
      hold   = '0;
      check("rst_ack", 32'(bus.ack), 0);
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_rv", 32'(bus.result_valid), 0);
      check("rst_out", 32'(obs_res), 0);
    end else begin
      exp_ack = '0;
      exp_rv  = 1'b0;
      if (m_idle) begin
        if (req_s != '0) begin
          g = -1;
          for (int k = 0; k < NReq; k++) begin
            if (g < 0 && req_s[(m_rr + k) % NReq]) g = (m_rr + k) % NReq;
          end
          exp_ack = NReq'(1) << g;
          sbq.push_back('{id: g, val: field(data_s[16*g +: 16])});
          m_rr   = (g + 1) % NReq;
          m_idle = 1'b0;
          m_cnt  = 10;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) begin
          exp_rv = 1'b1;
          m_idle = 1'b1;
        end
      end
      check("ack", 32'(bus.ack), 32'(exp_ack));
      check("result_valid", 32'(bus.result_valid), 32'(exp_rv));
      check("busy", 32'(bus.busy), 32'(!m_idle));
      if (bus.result_valid) begin
        check("sb_nonempty", sbq.size(), 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          check("res_id", 32'(bus.result_id), 32'(e.id));
          check("res_digits", 32'(obs_res[15:0]), 32'(to_bcd(e.val)));
          hold = {2'(e.id), to_bcd(e.val)};
        end
      end else begin
        check("hold", 32'(obs_res), 32'(hold));
      end
    end
  end

  task automatic wait_ack(output int t);
    bit found = 1'b0;
    t = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        found = 1'b1;
        t = cyc;
      end
    end
    check("ack_seen", 32'(found), 1);
  endtask

  task automatic wait_rv(output int t);
    bit found = 1'b0;
    t = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.result_valid) begin
        found = 1'b1;
        t = cyc;
      end
    end
    check("rv_seen", 32'(found), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ta, tr, tp;
    bus.req        = '0;
    bus.accel_data = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Single source, val 258
    bus.accel_data[15:0] = 16'h7F40;
    bus.req = 3'b001;
    wait_ack(ta);
    check("t1_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    wait_rv(tr);
    check("t1_latency", tr - ta, 10);
    check("t1_digits", 32'(obs_res), 32'h0258);

    // Full scale then minimum on source 2
    bus.accel_data[47:32] = 16'hC0FF;
    bus.req = 3'b100;
    wait_ack(ta);
    bus.req = '0;
    wait_rv(tr);
    check("t2_full", 32'(obs_res), 32'h21023);
    bus.accel_data[47:32] = 16'h8000;
    bus.req = 3'b100;
    wait_ack(ta);
    bus.req = '0;
    wait_rv(tr);
    check("t2_one", 32'(obs_res), 32'h20001);

    // Fairness with all sources requesting
    bus.accel_data = {16'h0003, 16'h0002, 16'h0001};
    bus.req = 3'b111;
    tp = -1;
    for (int n = 0; n < 4; n++) begin
      wait_rv(tr);
      check("t3_result", 32'(obs_res), 32'({2'(n % 3), to_bcd(4 * ((n % 3) + 1))}));
      if (tp >= 0) check("t3_period", tr - tp, 11);
      tp = tr;
    end
    bus.req = '0;
    repeat (2) @(negedge clk);

    // Reset five edges after capture
    bus.accel_data[15:0] = 16'h7F40;
    bus.req = 3'b001;
    wait_ack(ta);
    bus.req = '0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("t4_busy", 32'(bus.busy), 0);
    check("t4_outs", 32'(obs_res), 0);
    bus.accel_data[31:16] = 16'h1234;
    bus.req = 3'b010;
    wait_ack(ta);
    check("t4_ack", 32'(bus.ack), 32'h2);
    bus.req = '0;
    wait_rv(tr);
    check("t4_latency", tr - ta, 10);
    check("t4_result", 32'(obs_res), 32'h10208);

    // Inputs disturbed while a conversion is in flight
    bus.accel_data[15:0] = 16'h7F40;
    bus.req = 3'b001;
    wait_ack(ta);
    bus.accel_data = {16'hFFFF, 16'hFFFF, 16'hFFFF};
    bus.req = 3'b010;
    repeat (3) @(negedge clk);
    bus.req = '0;
    wait_rv(tr);
    check("t5_result", 32'(obs_res), 32'h00258);

    // Back-to-back: request still high in the result_valid cycle
    bus.accel_data[15:0] = 16'h0001;
    bus.req = 3'b001;
    wait_ack(ta);
    wait_rv(tr);
    @(negedge clk);
    check("t6_ack_next", 32'(bus.ack), 32'h1);
    check("t6_ack_cycle", cyc - tr, 1);
    bus.req = '0;
    wait_rv(tr);
    check("t6_result", 32'(obs_res), 32'h00004);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
